nmcu_mem_arbiter: RTL
=====================

# nmcu_mem_arbiter

Round-robin arbiter that shares the single NMCU memory path between up to NUM_REQ masters: control unit, DMA engine, and debug port. Sits between the masters and the cache/memory-interface path. Accepts one request at a time from the winning master, issues it downstream with a valid/ready handshake, and waits for the response. Routes the response back to the originating master, with a response timeout so a hung memory cannot lock the NMCU.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters (2..8)
- ADDR_W, 32: address width
- DATA_W, 32: data width
- TIMEOUT_CYC, 256: max cycles in WAIT before an error response (≥2)

Ports (vectors indexed by requester; payload arrays are [NUM_REQ]):
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  request pending per master
- req_ready_o  out  NUM_REQ  one-hot pulse: request captured
- req_we_i  in  NUM_REQ  1 = write, 0 = read
- req_addr_i  in  NUM_REQ×ADDR_W  request address
- req_wdata_i  in  NUM_REQ×DATA_W  write data
- resp_valid_o  out  NUM_REQ  one-hot, one-cycle response pulse
- resp_rdata_o  out  DATA_W  read data, shared by all masters, valid with resp_valid_o
- resp_err_o  out  1  timeout error, valid with resp_valid_o
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream accepts request
- mem_we_o, mem_addr_o, mem_wdata_o  out  1/ADDR_W/DATA_W  registered payload
- mem_rsp_valid_i  in  1  downstream response (reads and writes both acked)
- mem_rsp_rdata_i  in  DATA_W  response data
- stray_rsp_o  out  1  sticky: response seen outside WAIT; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, select the winner by round-robin, starting at index (last_grant+1) mod NUM_REQ.
  - Pulse req_ready_o[winner], latch the payload and the grant index, update last_grant, then go to ISSUE.
- ISSUE:
  - mem_req_valid_o=1 with the latched payload, held stable.
  - On mem_req_ready_i, go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_rsp_valid_i: latch rdata, set err=0, go to RESP. A response takes priority over expiry in the same cycle.
  - Else, when the counter reaches TIMEOUT_CYC-1: set rdata=0, err=1, go to RESP.
- RESP: resp_valid_o[grant]=1 for exactly one cycle, then go to IDLE.
- A master must hold req_valid_i and its payload until it sees req_ready_o. Deasserting req_valid_i earlier is permitted; that request is then never granted.
- mem_rsp_valid_i in IDLE, ISSUE or RESP is dropped and sets stray_rsp_o. This includes a late response after a timeout.
- Only one transaction is outstanding; all other masters stall.
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1, so master 0 wins first.
  - All outputs 0: req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_req_valid_o, payload, stray_rsp_o.
- Reset mid-transaction: abandon immediately, with no response to the master. The downstream path is reset by the same rst_n.

## Timing
- req_ready_o pulse is combinational from state==IDLE and req_valid_i. The payload is captured on that edge.
- mem_req_valid_o rises the cycle after grant.
- Minimum request-to-response latency: grant at cycle 0, issue at cycle 1 with ready at cycle 1, response at cycle 2, resp_valid_o at cycle 3. That is 3 cycles from grant plus the memory latency.
- Back-to-back grants: next grant can occur in the cycle after RESP, giving a minimum of 4 cycles per transaction.
- Timeout: resp_err_o pulses TIMEOUT_CYC+1 cycles after the ISSUE handshake.
- mem_req_valid_o never drops without mem_req_ready_i, except on reset.

## Structure
- Shared constants go in nmcu_pkg:
  - arb_state_e enum (IDLE, ISSUE, WAIT, RESP).
  - Default NUM_REQ and master index constants: MST_CU=0, MST_DMA=1, MST_DBG=2.
- One sub-module: rr_arbiter, a pure combinational round-robin pick.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant and index.
  - Reused by later schedulers.

## Test plan
- Single read: master 0 requests addr 0x100; memory gives ready immediately and responds 2 cycles later with 0xDEADBEEF -> resp_valid_o=3'b001 once, rdata 0xDEADBEEF, err 0.
- Fairness: all 3 masters hold valid continuously for 6 transactions -> grant order 0,1,2,0,1,2.
- Backpressure: mem_req_ready_i held low for 5 cycles -> mem_req_valid_o and payload stable for all 5 cycles, then one handshake.
- Timeout: TIMEOUT_CYC=16, memory never responds -> resp_err_o=1, rdata 0 on cycle 17 after issue. A later mem_rsp_valid_i sets stray_rsp_o.
- Simultaneous: response arrives exactly on the cycle the counter expires -> err=0, response data returned.
- Reset mid-WAIT: rst_n low for 2 cycles -> all outputs 0, no resp_valid_o. The next request from master 0 is granted first.

Source files
------------

// File: rtl/nmcu_pkg.sv
// -----------------------------------------------------------------------------
// nmcu_pkg
// Shared definitions for the NMCU memory-path arbiter and its siblings.
//   arb_state_e   : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   NMCU_NUM_REQ  : default number of memory masters
//   MST_*         : fixed requester indices (control unit, DMA, debug port)
// -----------------------------------------------------------------------------
package nmcu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int NMCU_NUM_REQ = 3;

  localparam int MST_CU  = 0;
  localparam int MST_DMA = 1;
  localparam int MST_DBG = 2;

endpackage

// File: rtl/nmcu_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// nmcu_mem_arbiter_if
// Bundles the requester-side and memory-side signals of the arbiter.
//   req_*   : per-master request handshake and payload ([NUM_REQ] arrays)
//   resp_*  : one-hot response pulse plus shared read data / error flag
//   mem_*   : single downstream valid/ready request and response channel
//   stray_rsp_o : sticky flag for responses arriving outside WAIT
// Modports: slave = arbiter view, master = masters + memory (environment) view.
// -----------------------------------------------------------------------------
interface nmcu_mem_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic [NUM_REQ-1:0] req_we_i;
  logic [ADDR_W-1:0]  req_addr_i  [NUM_REQ];
  logic [DATA_W-1:0]  req_wdata_i [NUM_REQ];

  logic [NUM_REQ-1:0] resp_valid_o;
  logic [DATA_W-1:0]  resp_rdata_o;
  logic               resp_err_o;

  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic               mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic               mem_rsp_valid_i;
  logic [DATA_W-1:0]  mem_rsp_rdata_i;

  logic               stray_rsp_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stray_rsp_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stray_rsp_o
  );

endinterface

// File: rtl/nmcu_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Pure combinational round-robin pick. The search starts at the requester
// after i_last and wraps, so the previous winner has lowest priority.
//   i_req   : request vector
//   i_last  : index of the previous winner
//   o_grant : one-hot winner (all zero when nothing requests)
//   o_idx   : binary winner index
//   o_any   : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(i_last) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmcu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// nmcu_mem_arbiter
// Shares the single NMCU memory path between NUM_REQ masters. One request is
// granted round-robin, issued downstream with valid/ready, and its response
// (or a timeout error) is returned to the originating master as a one-cycle
// pulse. Only one transaction is ever outstanding.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nmcu_mem_arbiter_if.slave (request, response, memory ports)
// -----------------------------------------------------------------------------
module nmcu_mem_arbiter
  import nmcu_pkg::*;
#(
  parameter int NUM_REQ     = NMCU_NUM_REQ,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nmcu_mem_arbiter_if.slave    bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e          r_state;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_grant;
  logic [CW-1:0]       r_cnt;
  logic                r_mem_req_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_stray;

  logic [NUM_REQ-1:0]  w_grant_vec;
  logic [IW-1:0]       w_grant_idx;
  logic                w_grant_any;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (bus.req_valid_i),
    .i_last  (r_last),
    .o_grant (w_grant_vec),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  // Ready is combinational so the winner sees it in the cycle it requests;
  // gated by rst_n so every output reads zero while reset is held.
  assign bus.req_ready_o     = (rst_n && r_state == IDLE) ? w_grant_vec : '0;

  assign bus.mem_req_valid_o = r_mem_req_valid;
  assign bus.mem_we_o        = r_mem_we;
  assign bus.mem_addr_o      = r_mem_addr;
  assign bus.mem_wdata_o     = r_mem_wdata;
  assign bus.resp_valid_o    = r_resp_valid;
  assign bus.resp_rdata_o    = r_resp_rdata;
  assign bus.resp_err_o      = r_resp_err;
  assign bus.stray_rsp_o     = r_stray;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is plain flops (no memory arrays), so every
    // register, payload included, is cleared by the asynchronous reset.
    if (!rst_n) begin
      r_state         <= IDLE;
      r_last          <= IW'(NUM_REQ - 1);
      r_grant         <= '0;
      r_cnt           <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_resp_valid    <= '0;
      r_resp_rdata    <= '0;
      r_resp_err      <= 1'b0;
      r_stray         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge register values regardless of statement order.
      if (bus.mem_rsp_valid_i && r_state != WAIT) begin
        r_stray <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_grant         <= w_grant_idx;
            r_last          <= w_grant_idx;
            r_mem_we        <= bus.req_we_i[w_grant_idx];
            r_mem_addr      <= bus.req_addr_i[w_grant_idx];
            r_mem_wdata     <= bus.req_wdata_i[w_grant_idx];
            r_mem_req_valid <= 1'b1;
            r_state         <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.mem_req_ready_i) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= WAIT;
          end
        end

        WAIT: begin
          // A real response wins over expiry in the same cycle.
          if (bus.mem_rsp_valid_i) begin
            r_resp_rdata <= bus.mem_rsp_rdata_i;
            r_resp_err   <= 1'b0;
            r_resp_valid <= ONE_HOT0 << r_grant;
            r_state      <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= ONE_HOT0 << r_grant;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RESP: begin
          r_resp_valid <= '0;
          r_state      <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
